// File: rtl/star_outport_arbiter_pkg.sv
// Shared types and helpers for the star hub output-port arbiter.
package star_outport_arbiter_pkg;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  // Ceiling log2, never below 1, so a 2-entry index still gets one bit.
  function automatic int log2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/star_rr_pick.sv
// Round-robin pick: first requester at or after ptr, wrapping modulo NE.
module star_rr_pick #(
  parameter int NE  = 8,
  parameter int EAw = 3
) (
  input  logic [NE-1:0]  req,
  input  logic [EAw-1:0] ptr,
  output logic [NE-1:0]  pick,
  output logic [EAw-1:0] pick_idx,
  output logic           any
);

  logic [2*NE-1:0] dbl;
  logic            found;
  int              start;
  int              pos;

  // The doubled vector turns the wrap-around search into one linear scan.
  assign dbl = {req, req};
  assign any = |req;

  always_comb begin
    start = int'(ptr);
    pos   = 0;
    found = 1'b0;
    for (int k = 0; k < 2*NE; k++) begin
      if (!found && (k >= start) && (k < start + NE) && dbl[k]) begin
        found = 1'b1;
        pos   = k;
      end
    end
    if (pos >= NE) pos = pos - NE;
    pick     = '0;
    pick_idx = '0;
    for (int j = 0; j < NE; j++) begin
      pick[j] = found && (pos == j);
    end
    if (found) pick_idx = EAw'(pos);
  end

endmodule

// File: rtl/star_outport_arbiter.sv
// Packet-level output-port arbiter: locks a requester head-to-tail, round-robin
// across packets, and gates every flit on credits for the downstream buffer.
module star_outport_arbiter
  import star_outport_arbiter_pkg::*;
#(
  parameter  int NE           = 8,
  parameter  int CREDIT_DEPTH = 4,
  localparam int EAw          = log2(NE),
  localparam int CNTw         = log2(CREDIT_DEPTH + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NE-1:0]   req,
  input  logic [NE-1:0]   is_tail,
  input  logic            credit_in,
  output logic [NE-1:0]   grant,
  output logic [EAw-1:0]  owner,
  output logic            busy,
  output logic [CNTw-1:0] credit_cnt,
  output logic            credit_err
);

  localparam logic [CNTw-1:0] CNT_FULL = CNTw'(CREDIT_DEPTH);

  arb_state_e     state;
  logic [EAw-1:0] rr_ptr;
  logic [NE-1:0]  pick;
  logic [EAw-1:0] pick_idx;
  logic           any;
  logic           xfer;
  logic           credit_ok;

  function automatic logic [EAw-1:0] ptr_inc(input logic [EAw-1:0] p);
    return (p == EAw'(NE - 1)) ? '0 : p + EAw'(1);
  endfunction

  star_rr_pick #(
    .NE  (NE),
    .EAw (EAw)
  ) u_pick (
    .req      (req),
    .ptr      (rr_ptr),
    .pick     (pick),
    .pick_idx (pick_idx),
    .any      (any)
  );

  assign credit_ok = (credit_cnt != '0);

  always_comb begin
    grant = '0;
    if (!reset && credit_ok) begin
      if (state == ARB_IDLE) begin
        grant = pick;
      end else begin
        // While locked, only the owner may move; a bubble just holds the lock.
        grant[owner] = req[owner];
      end
    end
  end

  assign xfer = |grant;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ARB_IDLE;
      rr_ptr <= '0;
      owner  <= '0;
      busy   <= 1'b0;
    end else if (state == ARB_IDLE) begin
      if (xfer) begin
        if (is_tail[pick_idx]) begin
          rr_ptr <= ptr_inc(pick_idx);
        end else begin
          state <= ARB_LOCKED;
          owner <= pick_idx;
          busy  <= 1'b1;
        end
      end
    end else begin
      if (xfer && is_tail[owner]) begin
        state  <= ARB_IDLE;
        busy   <= 1'b0;
        rr_ptr <= ptr_inc(owner);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      credit_cnt <= CNT_FULL;
      credit_err <= 1'b0;
    end else begin
      case ({xfer, credit_in})
        2'b10:   credit_cnt <= credit_cnt - CNTw'(1);
        2'b01: begin
          // A return with the buffer already empty is an upstream bug; hold and flag.
          if (credit_cnt == CNT_FULL) credit_err <= 1'b1;
          else                        credit_cnt <= credit_cnt + CNTw'(1);
        end
        default: credit_cnt <= credit_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_star_outport_arbiter.sv
// Directed bench: a 4-port/4-credit and a 5-port/2-credit arbiter, grant scoreboard.
module tb_star_outport_arbiter;

  logic       clk = 1'b0;
  logic       reset;

  logic [3:0] req4, tail4, grant4;
  logic       cin4, busy4, err4;
  logic [1:0] owner4;
  logic [2:0] cnt4;

  logic [4:0] req5, tail5, grant5;
  logic       cin5, busy5, err5;
  logic [2:0] owner5;
  logic [1:0] cnt5;

  typedef struct {
    bit         dut5;
    logic [4:0] g;
    int         id;
  } exp_t;

  exp_t sb[$];
  int   checks  = 0;
  int   passes  = 0;
  int   step_id = 0;

  always #5 clk = ~clk;

  star_outport_arbiter #(.NE(4), .CREDIT_DEPTH(4)) u4 (
    .clk        (clk),
    .reset      (reset),
    .req        (req4),
    .is_tail    (tail4),
    .credit_in  (cin4),
    .grant      (grant4),
    .owner      (owner4),
    .busy       (busy4),
    .credit_cnt (cnt4),
    .credit_err (err4)
  );

  star_outport_arbiter #(.NE(5), .CREDIT_DEPTH(2)) u5 (
    .clk        (clk),
    .reset      (reset),
    .req        (req5),
    .is_tail    (tail5),
    .credit_in  (cin5),
    .grant      (grant5),
    .owner      (owner5),
    .busy       (busy5),
    .credit_cnt (cnt5),
    .credit_err (err5)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Drive one cycle of u4 stimulus (u5 idle) and queue the grant it must produce.
  task automatic step4(input logic [3:0] r, input logic [3:0] t, input logic c,
                       input logic [3:0] g);
    exp_t e;
    req4 = r; tail4 = t; cin4 = c;
    req5 = '0; tail5 = '0; cin5 = 1'b0;
    e.dut5 = 1'b0; e.g = {1'b0, g}; e.id = step_id;
    step_id++;
    sb.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic step5(input logic [4:0] r, input logic [4:0] t, input logic c,
                       input logic [4:0] g);
    exp_t e;
    req5 = r; tail5 = t; cin5 = c;
    req4 = '0; tail4 = '0; cin4 = 1'b0;
    e.dut5 = 1'b1; e.g = g; e.id = step_id;
    step_id++;
    sb.push_back(e);
    @(posedge clk); #1;
  endtask

  // Grant is combinational: compare at the falling edge of the cycle it was driven in.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        if (e.dut5) chk($sformatf("grant5#%0d", e.id), 32'(grant5), 32'(e.g));
        else        chk($sformatf("grant4#%0d", e.id), 32'(grant4), 32'(e.g[3:0]));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    req4 = '0; tail4 = '0; cin4 = 1'b0;
    req5 = '0; tail5 = '0; cin5 = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset: grant held off even with requests present.
    step4(4'b1111, 4'b1111, 1'b0, 4'b0000);
    chk("rst_busy4", 32'(busy4), 32'd0);
    chk("rst_owner4", 32'(owner4), 32'd0);
    chk("rst_cnt4", 32'(cnt4), 32'd4);
    chk("rst_err4", 32'(err4), 32'd0);
    chk("rst_busy5", 32'(busy5), 32'd0);
    chk("rst_cnt5", 32'(cnt5), 32'd2);
    reset = 1'b0;

    // Fairness over single-flit packets, credits replenished each cycle.
    for (int i = 0; i < 8; i++) begin
      step4(4'b1111, 4'b1111, 1'b1, 4'(1 << (i % 4)));
      chk("fair_cnt", 32'(cnt4), 32'd4);
    end

    // Packet lock: move rr_ptr to 1, then requester 2 holds the port for 3 flits.
    step4(4'b0001, 4'b0001, 1'b1, 4'b0001);
    step4(4'b0101, 4'b0000, 1'b1, 4'b0100);
    chk("lock_busy1", 32'(busy4), 32'd1);
    chk("lock_owner", 32'(owner4), 32'd2);
    step4(4'b0101, 4'b0000, 1'b1, 4'b0100);
    chk("lock_busy2", 32'(busy4), 32'd1);
    step4(4'b0101, 4'b0100, 1'b1, 4'b0100);
    chk("lock_busy3", 32'(busy4), 32'd0);
    chk("lock_rr", 32'(u4.rr_ptr), 32'd3);
    step4(4'b0001, 4'b0001, 1'b1, 4'b0001);
    chk("lock_cnt", 32'(cnt4), 32'd4);

    // Credit drain, simultaneous xfer+credit at 1, stall at 0, refill, overflow.
    step4(4'b1111, 4'b1111, 1'b0, 4'b0010);
    step4(4'b1111, 4'b1111, 1'b0, 4'b0100);
    step4(4'b1111, 4'b1111, 1'b0, 4'b1000);
    chk("drain_cnt", 32'(cnt4), 32'd1);
    step4(4'b1111, 4'b1111, 1'b1, 4'b0001);
    chk("both_cnt", 32'(cnt4), 32'd1);
    step4(4'b1111, 4'b1111, 1'b0, 4'b0010);
    chk("empty_cnt", 32'(cnt4), 32'd0);
    step4(4'b1111, 4'b1111, 1'b0, 4'b0000);
    chk("stall_cnt", 32'(cnt4), 32'd0);
    for (int i = 1; i <= 4; i++) begin
      step4(4'b0000, 4'b0000, 1'b1, 4'b0000);
      chk("refill_cnt", 32'(cnt4), 32'(i));
    end
    chk("refill_err", 32'(err4), 32'd0);
    step4(4'b0000, 4'b0000, 1'b1, 4'b0000);
    chk("ovf_cnt", 32'(cnt4), 32'd4);
    chk("ovf_err", 32'(err4), 32'd1);
    step4(4'b0000, 4'b0000, 1'b0, 4'b0000);
    chk("ovf_sticky1", 32'(err4), 32'd1);
    step4(4'b0100, 4'b0100, 1'b0, 4'b0100);
    chk("ovf_sticky2", 32'(err4), 32'd1);
    chk("ovf_cnt2", 32'(cnt4), 32'd3);

    // Reset mid-packet with one credit left.
    step4(4'b0010, 4'b0000, 1'b0, 4'b0010);
    chk("mid_busy", 32'(busy4), 32'd1);
    chk("mid_owner", 32'(owner4), 32'd1);
    step4(4'b0010, 4'b0000, 1'b0, 4'b0010);
    chk("mid_cnt", 32'(cnt4), 32'd1);
    reset = 1'b1;
    step4(4'b0010, 4'b0000, 1'b0, 4'b0000);
    chk("mrst_busy", 32'(busy4), 32'd0);
    chk("mrst_cnt", 32'(cnt4), 32'd4);
    chk("mrst_err", 32'(err4), 32'd0);
    chk("mrst_owner", 32'(owner4), 32'd0);
    chk("mrst_rr", 32'(u4.rr_ptr), 32'd0);
    reset = 1'b0;
    step4(4'b0010, 4'b0010, 1'b0, 4'b0010);
    chk("mrst_cnt2", 32'(cnt4), 32'd3);

    // Credit stall with 2-deep buffer: requester 1, 4-flit packet.
    step5(5'b00010, 5'b00000, 1'b0, 5'b00010);
    chk("st_owner", 32'(owner5), 32'd1);
    step5(5'b00010, 5'b00000, 1'b0, 5'b00010);
    chk("st_cnt0", 32'(cnt5), 32'd0);
    step5(5'b00010, 5'b00000, 1'b0, 5'b00000);
    chk("st_busy", 32'(busy5), 32'd1);
    step5(5'b00010, 5'b00000, 1'b1, 5'b00000);
    chk("st_cnt1", 32'(cnt5), 32'd1);
    step5(5'b00010, 5'b00000, 1'b0, 5'b00010);
    step5(5'b00010, 5'b00000, 1'b0, 5'b00000);
    step5(5'b00010, 5'b00000, 1'b1, 5'b00000);
    step5(5'b00010, 5'b00010, 1'b0, 5'b00010);
    chk("st_done", 32'(busy5), 32'd0);
    step5(5'b00000, 5'b00000, 1'b1, 5'b00000);
    step5(5'b00000, 5'b00000, 1'b1, 5'b00000);
    chk("st_refill", 32'(cnt5), 32'd2);

    // Non-power-of-two wrap: 4 -> 0.
    step5(5'b01000, 5'b01000, 1'b1, 5'b01000);
    chk("wrap_rr4", 32'(u5.rr_ptr), 32'd4);
    step5(5'b10001, 5'b10001, 1'b1, 5'b10000);
    chk("wrap_rr0", 32'(u5.rr_ptr), 32'd0);
    step5(5'b10001, 5'b10001, 1'b1, 5'b00001);
    chk("wrap_cnt", 32'(cnt5), 32'd2);
    chk("wrap_err", 32'(err5), 32'd0);

    @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
